// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the scanned BCD 7-seg driver.
//   SEG_0..SEG_9, SEG_OFF : segment codes, bit order {g,f,e,d,c,b,a}, active-high
//   conv_state_e          : conversion FSM states
//   bcd_to_seg()          : BCD digit -> segment code (non-BCD codes show blank)
//   clog2()               : counter width helper
//   dec_digits()          : decimal digits needed to hold any w-bit binary value
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP,
        ST_SHIFT,
        ST_NEXT,
        ST_COMMIT
    } conv_state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // floor(w*log10(2))+1; 2^w is never a power of ten, so this also
    // counts the digits of 2^w-1.
    function automatic int dec_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// bcd_dd_serial: one-channel sequential double-dabble converter.
//   clock, rst_n : clock, async active-low reset
//   start        : load bin and clear the BCD accumulator (1 cycle)
//   bin          : binary value, sampled on the start edge
//   done         : high during the last shift cycle; bcd/ovf are valid from
//                  the following cycle until the next start
//   bcd          : DIGITS BCD digits, saturated to all-9s on overflow
//   ovf          : value did not fit in DIGITS decimal digits
module bcd_dd_serial import seg_pkg::*; #(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    // Accumulator is wide enough for any VAL_W-bit value so overflow can be
    // read straight off the digits above DIGITS.
    localparam int NEED  = dec_digits(VAL_W);
    localparam int FULL  = (NEED > DIGITS) ? NEED : DIGITS;
    localparam int CNT_W = (clog2(VAL_W) < 1) ? 1 : clog2(VAL_W);

    logic [VAL_W-1:0]  sh;
    logic [4*FULL-1:0] acc;
    logic [4*FULL-1:0] adj;
    logic [CNT_W-1:0]  cnt;
    logic              active;

    always_comb begin
        adj = acc;
        for (int i = 0; i < FULL; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    assign done = active && (cnt == CNT_W'(VAL_W - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            sh     <= bin;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            // Top digit of adj is always 0 because FULL covers the input range.
            {acc, sh} <= {adj[4*FULL-2:0], sh, 1'b0};
            cnt       <= cnt + CNT_W'(1);
            if (done) active <= 1'b0;
        end
    end

    generate
        if (FULL > DIGITS) begin : g_ovf
            assign ovf = |acc[4*FULL-1:4*DIGITS];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    assign bcd = ovf ? {DIGITS{4'h9}} : acc[4*DIGITS-1:0];

endmodule

// File: rtl/seg_scan_bcd.sv
// seg_scan_bcd: NUM_CH binary values -> BCD (one shared serial converter)
// -> time-multiplexed 7-seg banks, one bank of DIGITS digits per channel.
//   clock, rst_n : clock, async active-low reset
//   value        : packed inputs, channel c at [c*VAL_W +: VAL_W]
//   load         : 1-cycle request to capture value and convert
//   lz_blank     : blank leading zeros (digit 0 always shows)
//   seg          : per channel {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   dig          : per channel one-hot digit select, polarity per DIG_ACT_LOW
//   busy         : conversion in progress
//   ovf          : per channel, value exceeded 10^DIGITS-1 at last commit
module seg_scan_bcd import seg_pkg::*; #(
    parameter int VAL_W       = 14,
    parameter int DIGITS      = 4,
    parameter int NUM_CH      = 2,
    parameter int SCAN_DIV    = 18562,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [NUM_CH*VAL_W-1:0]   value,
    input  logic                      load,
    input  logic                      lz_blank,
    output logic [NUM_CH*8-1:0]       seg,
    output logic [NUM_CH*DIGITS-1:0]  dig,
    output logic                      busy,
    output logic [NUM_CH-1:0]         ovf
);

    localparam int CH_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
    localparam int DIG_W  = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
    localparam int SCAN_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);

    localparam logic [NUM_CH*8-1:0]      SEG_RST = {(NUM_CH*8){SEG_ACT_LOW != 0}};
    localparam logic [NUM_CH*DIGITS-1:0] DIG_RST = {(NUM_CH*DIGITS){DIG_ACT_LOW != 0}};

    // ---------------- conversion control ----------------
    conv_state_e state, state_nx;

    logic [NUM_CH-1:0][VAL_W-1:0]    val_q;
    logic [CH_W-1:0]                 ch, ch_sel;
    logic                            pending;
    logic                            capture;
    logic [NUM_CH-1:0][4*DIGITS-1:0] stage_bcd, disp_bcd;
    logic [NUM_CH-1:0]               stage_ovf;

    logic                 dd_start, dd_done, dd_ovf;
    logic [VAL_W-1:0]     dd_bin;
    logic [4*DIGITS-1:0]  dd_bcd;

    assign busy = (state != ST_IDLE);

    // CAP starts channel 0; NEXT harvests channel ch and starts ch+1 in the
    // same cycle. The last channel goes straight from SHIFT to COMMIT, which
    // gives NUM_CH*(VAL_W+1)+1 busy cycles.
    always_comb begin
        state_nx = state;
        dd_start = 1'b0;
        ch_sel   = ch;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nx = ST_CAP;
                    capture  = 1'b1;
                end
            end
            ST_CAP: begin
                dd_start = 1'b1;
                ch_sel   = '0;
                state_nx = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (dd_done) state_nx = (ch == CH_W'(NUM_CH - 1)) ? ST_COMMIT : ST_NEXT;
            end
            ST_NEXT: begin
                dd_start = 1'b1;
                ch_sel   = ch + CH_W'(1);
                state_nx = ST_SHIFT;
            end
            ST_COMMIT: begin
                // A load landing in the commit cycle restarts just like a
                // pending one, so busy never drops between the two.
                if (pending || load) begin
                    state_nx = ST_CAP;
                    capture  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign dd_bin = val_q[ch_sel];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            ch        <= '0;
            val_q     <= '0;
            stage_bcd <= '0;
            stage_ovf <= '0;
            disp_bcd  <= '0;
            ovf       <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_sel;
            if (capture) val_q <= value;
            if (state == ST_COMMIT)  pending <= 1'b0;
            else if (busy && load)   pending <= 1'b1;
            if (state == ST_NEXT) begin
                stage_bcd[ch] <= dd_bcd;
                stage_ovf[ch] <= dd_ovf;
            end
            // All channels land together so the display is never half-updated.
            if (state == ST_COMMIT) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (c == NUM_CH - 1) begin
                        disp_bcd[c] <= dd_bcd;
                        ovf[c]      <= dd_ovf;
                    end else begin
                        disp_bcd[c] <= stage_bcd[c];
                        ovf[c]      <= stage_ovf[c];
                    end
                end
            end
        end
    end

    bcd_dd_serial #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_dd (
        .clock (clock),
        .rst_n (rst_n),
        .start (dd_start),
        .bin   (dd_bin),
        .done  (dd_done),
        .bcd   (dd_bcd),
        .ovf   (dd_ovf)
    );

    // ---------------- scan ----------------
    logic [SCAN_W-1:0]          scan_cnt;
    logic [DIG_W-1:0]           idx;
    logic                       tick;
    logic [NUM_CH*8-1:0]        seg_nx;
    logic [NUM_CH*DIGITS-1:0]   dig_nx;

    assign tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        logic [3:0]        cur;
        logic              upper_nz;
        logic [7:0]        raw;
        logic [DIGITS-1:0] oh;
        seg_nx = '0;
        dig_nx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur      = disp_bcd[c][4*idx +: 4];
            upper_nz = 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                if (d >= int'(idx) && disp_bcd[c][4*d +: 4] != 4'd0) upper_nz = 1'b1;
            end
            // dp stays off; blank only above the highest non-zero digit.
            if (lz_blank && idx != '0 && !upper_nz) raw = {1'b0, SEG_OFF};
            else                                    raw = {1'b0, bcd_to_seg(cur)};
            oh = DIGITS'(1) << idx;
            seg_nx[c*8 +: 8]           = (SEG_ACT_LOW != 0) ? ~raw : raw;
            dig_nx[c*DIGITS +: DIGITS] = (DIG_ACT_LOW != 0) ? ~oh  : oh;
        end
    end

    // seg and dig load from the same index on the same edge: no ghosting.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_RST;
            dig      <= DIG_RST;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + SCAN_W'(1);
            if (tick) begin
                idx <= (idx == DIG_W'(DIGITS - 1)) ? '0 : idx + DIG_W'(1);
                seg <= seg_nx;
                dig <= dig_nx;
            end
        end
    end

endmodule
